conv_filter_pipe: RTL

CONV_FILTER_PIPE -- requirements
Module: conv_filter_pipe

---
 rtl/conv_filter_pipe_if.sv | 27 ++
 rtl/conv_filter_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/conv_filter_pipe_if.sv
// Window-in / result-out handshake bundle for conv_filter_pipe.
interface conv_filter_pipe_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned ACC_W  = PIX_W + 1 + COEF_W + $clog2(K * K)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [K*K*PIX_W-1:0]        win_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUT_W-1:0]            out_pix;
    logic signed [ACC_W-1:0]     out_acc;
    logic                        out_sat;

    modport master (
        output in_valid, win_data, out_ready,
        input  in_ready, out_valid, out_pix, out_acc, out_sat
    );

    modport slave (
        input  in_valid, win_data, out_ready,
        output in_ready, out_valid, out_pix, out_acc, out_sat
    );
endinterface

// File: rtl/conv_filter_pipe.sv
// KxK convolution: multiply, adder tree, then round/shift/clamp, with a single
// global stall and double-buffered coefficient banks.
module conv_filter_pipe #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned ACC_W  = PIX_W + 1 + COEF_W + $clog2(K * K)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    conv_filter_pipe_if.slave        bus,
    input  logic                     coef_we_i,
    input  logic [4:0]               coef_addr_i,
    input  logic signed [COEF_W-1:0] coef_wdata_i,
    input  logic                     coef_commit_i,
    input  logic [3:0]               shift_i,
    input  logic [1:0]               mode_i
);
    localparam int unsigned TAPS   = K * K;
    localparam int unsigned PROD_W = PIX_W + 1 + COEF_W;
    localparam int unsigned CTR    = (TAPS - 1) / 2;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {
        MODE_CLAMP  = 2'b00,
        MODE_ABS    = 2'b01,
        MODE_BYPASS = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    logic signed [COEF_W-1:0] shadow_q [TAPS];
    logic signed [COEF_W-1:0] shadow_d [TAPS];
    logic signed [COEF_W-1:0] active_q [TAPS];

    logic                      adv;
    logic signed [PROD_W-1:0]  prod_d [TAPS];
    logic signed [PROD_W-1:0]  prod_q [TAPS];
    logic                      s1_valid_q;
    logic [PIX_W-1:0]          s1_ctr_q;
    mode_e                     s1_mode_q;
    logic [3:0]                s1_shift_q;

    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   s2_acc_q;
    logic                      s2_valid_q;
    logic [PIX_W-1:0]          s2_ctr_q;
    mode_e                     s2_mode_q;
    logic [3:0]                s2_shift_q;

    logic signed [SUM_W-1:0]   rnd;
    logic signed [SUM_W-1:0]   sum_r;
    logic signed [SUM_W-1:0]   shifted;
    logic signed [SUM_W-1:0]   mag;
    logic [OUT_W-1:0]          pix_d;
    logic                      sat_d;

    logic                      out_valid_q;
    logic [OUT_W-1:0]          out_pix_q;
    logic signed [ACC_W-1:0]   out_acc_q;
    logic                      out_sat_q;

    // Whole pipe moves together; only a held result blocks it.
    assign adv          = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = adv;

    // Shadow write is visible to a same-cycle commit.
    always_comb begin
        shadow_d = shadow_q;
        if (coef_we_i) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                if (coef_addr_i == 5'(i)) shadow_d[i] = coef_wdata_i;
            end
        end
    end

    // Coefficient banks update regardless of stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            if (coef_commit_i) active_q <= shadow_d;
        end
    end

    // S1: unsigned pixel times signed coefficient, full precision.
    always_comb begin
        for (int i = 0; i < int'(TAPS); i++) begin
            prod_d[i] = PROD_W'($signed({1'b0, bus.win_data[i*PIX_W +: PIX_W]}))
                      * PROD_W'(active_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ctr_q   <= '0;
            s1_mode_q  <= MODE_CLAMP;
            s1_shift_q <= '0;
            for (int i = 0; i < int'(TAPS); i++) prod_q[i] <= '0;
        end else if (adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                prod_q     <= prod_d;
                s1_ctr_q   <= bus.win_data[CTR*PIX_W +: PIX_W];
                s1_mode_q  <= mode_e'(mode_i);
                s1_shift_q <= shift_i;
            end
        end
    end

    // S2: adder tree over sign-extended products.
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < int'(TAPS); i++) acc_d = acc_d + ACC_W'(prod_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_acc_q   <= '0;
            s2_ctr_q   <= '0;
            s2_mode_q  <= MODE_CLAMP;
            s2_shift_q <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_acc_q   <= acc_d;
                s2_ctr_q   <= s1_ctr_q;
                s2_mode_q  <= s1_mode_q;
                s2_shift_q <= s1_shift_q;
            end
        end
    end

    // S3: round half up, arithmetic shift, then mode-dependent clamp.
    always_comb begin
        rnd     = (s2_shift_q == 4'd0) ? '0 : (SUM_W'(1) <<< (s2_shift_q - 4'd1));
        sum_r   = SUM_W'(s2_acc_q) + rnd;
        shifted = sum_r >>> s2_shift_q;
        mag     = (shifted < 0) ? -shifted : shifted;
        pix_d   = '0;
        sat_d   = 1'b0;
        case (s2_mode_q)
            MODE_BYPASS: pix_d = OUT_W'(s2_ctr_q);
            MODE_ABS: begin
                if (mag > PIX_MAX) begin
                    pix_d = OUT_W'(PIX_MAX);
                    sat_d = 1'b1;
                end else begin
                    pix_d = OUT_W'(mag);
                end
            end
            default: begin
                if (shifted < 0) begin
                    sat_d = 1'b1;
                end else if (shifted > PIX_MAX) begin
                    pix_d = OUT_W'(PIX_MAX);
                    sat_d = 1'b1;
                end else begin
                    pix_d = OUT_W'(shifted);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_pix_q <= pix_d;
                out_acc_q <= s2_acc_q;
                out_sat_q <= sat_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_pix   = out_pix_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
endmodule
